// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between the MEM-stage memory port and data_ram.
// Stores queue in a circular FIFO and drain whenever no load holds the RAM port.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_ce_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [3:0]    cpu_sel_i,
  input  logic [DW-1:0] cpu_data_i,
  output logic [DW-1:0] cpu_data_o,
  output logic          stall_req_o,
  output logic          ram_ce_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [3:0]    ram_sel_o,
  output logic [DW-1:0] ram_data_o,
  input  logic [DW-1:0] ram_data_i,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NB = 4;

  logic [AW-3:0] addr_q [DEPTH];
  logic [NB-1:0] sel_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] fwd_idx;

  logic is_load;
  logic is_store;
  logic full;
  logic do_enq;
  logic do_drain;

  // Reset gates every request so discarded entries never reach the RAM port.
  assign is_load     = !rst && cpu_ce_i && !cpu_we_i;
  assign is_store    = !rst && cpu_ce_i && cpu_we_i;
  assign full        = (count == CW'(DEPTH));
  assign do_enq      = is_store && !full;
  assign do_drain    = !rst && !is_load && (count != '0);
  assign stall_req_o = is_store && full;
  assign empty_o     = (count == '0);

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    if (is_load) begin
      ram_ce_o   = 1'b1;
      ram_addr_o = cpu_addr_i;
      ram_sel_o  = cpu_sel_i;
    end else if (do_drain) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = 1'b1;
      ram_addr_o = {addr_q[rd_ptr], 2'b00};
      ram_sel_o  = sel_q[rd_ptr];
      ram_data_o = data_q[rd_ptr];
    end
  end

  // Walk live entries oldest to youngest so the youngest matching lane wins.
  always_comb begin
    fwd_idx    = '0;
    cpu_data_o = '0;
    if (is_load) begin
      cpu_data_o = ram_data_i;
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = rd_ptr + PW'(i);
        if ((CW'(i) < count) && (addr_q[fwd_idx] == cpu_addr_i[AW-1:2])) begin
          for (int b = 0; b < NB; b++) begin
            if (sel_q[fwd_idx][b]) cpu_data_o[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end

  // NOTE: the payload array is deliberately not reset; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      addr_q[wr_ptr] <= cpu_addr_i[AW-1:2];
      sel_q[wr_ptr]  <= cpu_sel_i;
      data_q[wr_ptr] <= cpu_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq)   wr_ptr <= wr_ptr + PW'(1);
      if (do_drain) rd_ptr <= rd_ptr + PW'(1);
      if (do_enq && !do_drain)      count <= count + CW'(1);
      else if (!do_enq && do_drain) count <= count - CW'(1);
    end
  end

endmodule
